// File: rtl/sram_like_ram_slave.sv
// sram_like responder backed by a word-addressed RAM.
// Accepted requests are answered in order after a fixed LATENCY, with up to OUTSTANDING in flight.
module sram_like_ram_slave #(
    parameter int ADDR_BITS   = 12,
    parameter int LATENCY     = 2,
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_like_req,
    input  logic        sram_like_wr,
    input  logic [1:0]  sram_like_size,
    input  logic [31:0] sram_like_addr,
    input  logic [31:0] sram_like_wdata,
    output logic        sram_like_addr_ok,
    output logic [31:0] sram_like_rdata,
    output logic        sram_like_data_ok
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam int AGE_W = 4;

    typedef struct packed {
        logic [31:0]      rdata;
        logic [AGE_W-1:0] age;
    } entry_t;

    entry_t             fifo [OUTSTANDING];
    logic [31:0]        mem  [2**ADDR_BITS];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [ADDR_BITS-1:0] idx;
    logic [3:0]         base;
    logic [3:0]         strobe;
    logic               accept;
    logic               retire;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign idx = sram_like_addr[ADDR_BITS+1:2];

    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    always_comb begin
        base = 4'b1111;
        case (sram_like_size)
            2'd0:    base = 4'b0001;
            2'd1:    base = 4'b0011;
            default: base = 4'b1111;
        endcase
    end

    assign strobe = base << sram_like_addr[1:0];

    // Slot check excludes the entry retiring this cycle: no same-cycle bypass.
    assign sram_like_addr_ok = sram_like_req & ~rst & (count < CNT_W'(OUTSTANDING));
    assign accept            = sram_like_req & sram_like_addr_ok;

    assign retire = ~rst & (count != '0) & (fifo[rd_ptr].age == AGE_W'(LATENCY - 1));
    assign sram_like_data_ok = retire;
    assign sram_like_rdata   = retire ? fifo[rd_ptr].rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= ptr_inc(wr_ptr);
            if (retire) rd_ptr <= ptr_inc(rd_ptr);
            case ({accept, retire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Slot payload and age need no reset: they are only looked at while count says the slot is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < OUTSTANDING; i++) begin
            if (accept && wr_ptr == PTR_W'(i)) begin
                fifo[i].rdata <= sram_like_wr ? 32'h0 : mem[idx];
                fifo[i].age   <= '0;
            end else begin
                fifo[i].age   <= fifo[i].age + AGE_W'(1);
            end
        end
    end

    // NOTE: the RAM array is deliberately never reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (accept && sram_like_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (strobe[b]) mem[idx][8*b +: 8] <= sram_like_wdata[8*b +: 8];
            end
        end
    end

endmodule
